// File: rtl/store_buffer.sv
// Store buffer in front of the single-ported data memory: loads take the port first, stores drain when it is free.
// Optional feature macro SB_FWD_EN: a load that hits a buffered store takes that data instead of stalling.
module store_buffer #(
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned ADDR_WIDTH = 16,
  localparam int unsigned CW        = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [ADDR_WIDTH-1:0] st_addr,
  input  logic [15:0]           st_data,
  input  logic                  ld_valid,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  output logic                  ld_stall,
  output logic [15:0]           ld_data,
  output logic                  mem_en,
  output logic                  mem_wr,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [15:0]           mem_wdata,
  input  logic [15:0]           mem_rdata,
  output logic                  empty,
  output logic [CW-1:0]         count,
  output logic                  align_err
);
  localparam int unsigned DW = 16;
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned WA = ADDR_WIDTH - 1;

  // Only aligned stores are buffered, so entries keep the word address.
  logic [WA-1:0] r_addr [DEPTH];
  logic [DW-1:0] r_data [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_align_err;

  logic          w_full;
  logic          w_push;
  logic          w_pop;
  logic          w_st_mis;
  logic          w_ld_ok;
  logic          w_match;
`ifdef SB_FWD_EN
  logic [DW-1:0] w_fwd_data;
`endif

  assign w_full    = (r_count == CW'(DEPTH));
  assign st_ready  = ~rst & ~w_full;
  assign w_push    = st_valid & st_ready & ~st_addr[0];
  assign w_st_mis  = st_valid & st_ready & st_addr[0];
  assign w_ld_ok   = ld_valid & ~ld_addr[0];
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign align_err = r_align_err;

  // Scan oldest to youngest so the last hit is the youngest matching entry.
  always_comb begin
    w_match = 1'b0;
`ifdef SB_FWD_EN
    w_fwd_data = '0;
`endif
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if ((CW'(i) < r_count) &&
          (r_addr[r_head + PW'(i)] == ld_addr[ADDR_WIDTH-1:1])) begin
        w_match = 1'b1;
`ifdef SB_FWD_EN
        w_fwd_data = r_data[r_head + PW'(i)];
`endif
      end
    end
  end

  // Memory port arbitration: forced drain, load, hazard, background drain, idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = ld_addr;
    mem_wdata = r_data[r_head];
    ld_stall  = 1'b0;
    ld_data   = '0;
    w_pop     = 1'b0;
    if (rst) begin
      w_pop = 1'b0;
    end else if (w_full && st_valid) begin
      w_pop    = 1'b1;
      ld_stall = ld_valid;
    end else if (w_ld_ok && !w_match) begin
      mem_en  = 1'b1;
      ld_data = mem_rdata;
    end else if (w_ld_ok && w_match) begin
      w_pop = 1'b1;
`ifdef SB_FWD_EN
      ld_data = w_fwd_data;
`else
      ld_stall = 1'b1;
`endif
    end else if (r_count != '0) begin
      w_pop = 1'b1;
    end
    if (w_pop) begin
      mem_en   = 1'b1;
      mem_wr   = 1'b1;
      mem_addr = {r_addr[r_head], 1'b0};
    end
  end

  // Control state; a reset mid-drain simply discards the remaining entries.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_align_err <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + PW'(1);
      if (w_pop)  r_head <= r_head + PW'(1);
      r_count     <= r_count + CW'(w_push) - CW'(w_pop);
      r_align_err <= (ld_valid & ld_addr[0] & ~ld_stall) | w_st_mis;
    end
  end

  // Entry storage needs no reset: validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_tail] <= st_addr[ADDR_WIDTH-1:1];
      r_data[r_tail] <= st_data;
    end
  end

endmodule
